// File: rtl/ysyx_23060061_wbu.sv
// Write-back unit of the multi-cycle NPC core.
// Takes one retiring instruction from the LSU per handshake. It selects the
// write-back value, pulses the register-file write port for one cycle, and
// then offers a commit handshake to the IFU. It also keeps a 64-bit count of
// retired instructions.
//
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   lsu_valid/wbu_ready  LSU -> WBU handshake (ready only in IDLE)
//   memDataR, aluResult,
//   snpc, csrRData       write-back candidates, chosen by wbSel
//   RegWrite, rd         destination write enable and index
//   pc, dnpc             PC and dynamic next PC of the instruction
//   rf_wen/waddr/wdata   register-file write port
//   wbu_valid/ifu_ready  WBU -> IFU commit handshake
//   commit_pc/dnpc       captured pc/dnpc of the committing instruction
//   instret              retired-instruction counter (wraps mod 2^64)
module ysyx_23060061_wbu (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  output logic        wbu_ready,
  input  logic [31:0] memDataR,
  input  logic [31:0] aluResult,
  input  logic [31:0] snpc,
  input  logic [31:0] csrRData,
  input  logic [1:0]  wbSel,
  input  logic        RegWrite,
  input  logic [4:0]  rd,
  input  logic [31:0] pc,
  input  logic [31:0] dnpc,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        wbu_valid,
  input  logic        ifu_ready,
  output logic [31:0] commit_pc,
  output logic [31:0] commit_dnpc,
  output logic [63:0] instret
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] wb_value;

  always_comb begin
    wb_value = aluResult;
    unique case (wbSel)
      2'b00: wb_value = aluResult;
      2'b01: wb_value = memDataR;
      2'b10: wb_value = snpc;
      2'b11: wb_value = csrRData;
      default: wb_value = aluResult;
    endcase
  end

  // The write qualifier (RegWrite && rd != 0) is folded into rf_wen at
  // capture time, so rf_wen serves as the captured RegWrite and is high
  // only for the single WRITE cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      wbu_ready   <= 1'b1;
      wbu_valid   <= 1'b0;
      rf_wen      <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      commit_pc   <= '0;
      commit_dnpc <= '0;
      instret     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (lsu_valid) begin
            rf_wdata    <= wb_value;
            rf_waddr    <= rd;
            rf_wen      <= RegWrite && (rd != 5'd0);
            commit_pc   <= pc;
            commit_dnpc <= dnpc;
            wbu_ready   <= 1'b0;
            state       <= WRITE;
          end
        end
        WRITE: begin
          rf_wen    <= 1'b0;
          wbu_valid <= 1'b1;
          state     <= COMMIT;
        end
        COMMIT: begin
          if (ifu_ready) begin
            instret   <= instret + 64'd1;
            wbu_valid <= 1'b0;
            wbu_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          wbu_ready <= 1'b1;
          wbu_valid <= 1'b0;
          rf_wen    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_wbu.sv
// Directed self-checking bench for ysyx_23060061_wbu.
module tb_ysyx_23060061_wbu;

  logic        clk;
  logic        rst;
  logic        lsu_valid;
  logic        wbu_ready;
  logic [31:0] memDataR;
  logic [31:0] aluResult;
  logic [31:0] snpc;
  logic [31:0] csrRData;
  logic [1:0]  wbSel;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] pc;
  logic [31:0] dnpc;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wbu_valid;
  logic        ifu_ready;
  logic [31:0] commit_pc;
  logic [31:0] commit_dnpc;
  logic [63:0] instret;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned wen_cnt  = 0;
  int unsigned wen_snap;
  int unsigned valid_cnt;

  ysyx_23060061_wbu dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .wbu_ready(wbu_ready),
    .memDataR(memDataR), .aluResult(aluResult), .snpc(snpc), .csrRData(csrRData),
    .wbSel(wbSel), .RegWrite(RegWrite), .rd(rd), .pc(pc), .dnpc(dnpc),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wbu_valid(wbu_valid), .ifu_ready(ifu_ready),
    .commit_pc(commit_pc), .commit_dnpc(commit_dnpc), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and sample 1 ns later; counts write pulses.
  task automatic step();
    @(posedge clk);
    #1;
    if (rf_wen === 1'b1) wen_cnt++;
  endtask

  task automatic set_inputs(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] mem,
                            input logic [31:0] sn, input logic [31:0] csr, input logic rw,
                            input logic [4:0] r, input logic [31:0] p, input logic [31:0] dn);
    wbSel = sel; aluResult = alu; memDataR = mem; snpc = sn; csrRData = csr;
    RegWrite = rw; rd = r; pc = p; dnpc = dn;
  endtask

  // Accept, WRITE cycle, COMMIT with `stall` cycles of ifu_ready low, commit.
  task automatic run_instr(input string tag, input logic exp_wen, input logic [4:0] exp_addr,
                           input logic [31:0] exp_data, input logic [31:0] exp_pc,
                           input logic [31:0] exp_dnpc, input int unsigned stall,
                           input logic [63:0] exp_instret);
    lsu_valid = 1'b1;
    ifu_ready = 1'b0;
    step();
    lsu_valid = 1'b0;
    check({tag, ".wen"},   {63'd0, rf_wen}, {63'd0, exp_wen});
    check({tag, ".ready"}, {63'd0, wbu_ready}, 64'd0);
    check({tag, ".valid_w"}, {63'd0, wbu_valid}, 64'd0);
    if (exp_wen) begin
      check({tag, ".waddr"}, {59'd0, rf_waddr}, {59'd0, exp_addr});
      check({tag, ".wdata"}, {32'd0, rf_wdata}, {32'd0, exp_data});
    end
    // Scramble inputs: captured state must not follow them.
    set_inputs(2'b00, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004,
               1'b1, 5'd31, 32'hDEAD_0005, 32'hDEAD_0006);
    step();
    valid_cnt = 0;
    for (int unsigned i = 0; i < stall; i++) begin
      if (wbu_valid === 1'b1) valid_cnt++;
      check({tag, ".stall_wen"}, {63'd0, rf_wen}, 64'd0);
      check({tag, ".stall_rdy"}, {63'd0, wbu_ready}, 64'd0);
      pc = pc + 32'd4;
      step();
    end
    if (wbu_valid === 1'b1) valid_cnt++;
    check({tag, ".valid_cycles"}, 64'(valid_cnt), 64'(stall + 1));
    check({tag, ".commit_pc"},   {32'd0, commit_pc},   {32'd0, exp_pc});
    check({tag, ".commit_dnpc"}, {32'd0, commit_dnpc}, {32'd0, exp_dnpc});
    ifu_ready = 1'b1;
    step();
    ifu_ready = 1'b0;
    check({tag, ".ready_back"}, {63'd0, wbu_ready}, 64'd1);
    check({tag, ".valid_off"},  {63'd0, wbu_valid}, 64'd0);
    check({tag, ".instret"},    instret, exp_instret);
  endtask

  initial begin
    rst = 1'b0; lsu_valid = 1'b0; ifu_ready = 1'b0;
    set_inputs(2'($urandom), $urandom, $urandom, $urandom, $urandom,
               1'($urandom), 5'($urandom), $urandom, $urandom);

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      lsu_valid = 1'($urandom); ifu_ready = 1'($urandom);
      set_inputs(2'($urandom), $urandom, $urandom, $urandom, $urandom,
                 1'($urandom), 5'($urandom), $urandom, $urandom);
      step();
    end
    check("rst.ready", {63'd0, wbu_ready}, 64'd1);
    check("rst.valid", {63'd0, wbu_valid}, 64'd0);
    check("rst.wen",   {63'd0, rf_wen}, 64'd0);
    check("rst.waddr", {59'd0, rf_waddr}, 64'd0);
    check("rst.wdata", {32'd0, rf_wdata}, 64'd0);
    check("rst.cpc",   {32'd0, commit_pc}, 64'd0);
    check("rst.cdnpc", {32'd0, commit_dnpc}, 64'd0);
    check("rst.instret", instret, 64'd0);
    rst = 1'b1; lsu_valid = 1'b0; ifu_ready = 1'b0;
    step();
    wen_cnt = 0;

    // Reset while in COMMIT: abandoned instruction must not count
    set_inputs(2'b00, 32'h0000_0042, 32'h0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h8000_0100, 32'h8000_0104);
    lsu_valid = 1'b1;
    step();
    lsu_valid = 1'b0;
    step();
    check("rstc.in_commit", {63'd0, wbu_valid}, 64'd1);
    wen_snap = wen_cnt;
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("rstc.valid", {63'd0, wbu_valid}, 64'd0);
    check("rstc.ready", {63'd0, wbu_ready}, 64'd1);
    check("rstc.instret", instret, 64'd0);
    step(); step();
    check("rstc.no_extra_wen", 64'(wen_cnt), 64'(wen_snap));
    check("rstc.one_wen", 64'(wen_cnt), 64'd1);

    // ALU write
    wen_cnt = 0;
    set_inputs(2'b00, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h8000_0000, 32'h8000_0004);
    run_instr("alu", 1'b1, 5'd5, 32'h0000_1234, 32'h8000_0000, 32'h8000_0004, 0, 64'd1);
    check("alu.wen_pulses", 64'(wen_cnt), 64'd1);

    // Load with 4-cycle IFU stall
    wen_cnt = 0;
    set_inputs(2'b01, 32'h0000_0001, 32'hFFFF_FF80, 32'h0, 32'h0, 1'b1, 5'd10, 32'h8000_0010, 32'h8000_0014);
    run_instr("load", 1'b1, 5'd10, 32'hFFFF_FF80, 32'h8000_0010, 32'h8000_0014, 4, 64'd2);
    check("load.wen_pulses", 64'(wen_cnt), 64'd1);

    // x0 destination, then non-writing instruction
    wen_cnt = 0;
    set_inputs(2'b00, 32'h0000_5555, 32'h0, 32'h0, 32'h0, 1'b1, 5'd0, 32'h8000_0020, 32'h8000_0024);
    run_instr("x0", 1'b0, 5'd0, 32'h0, 32'h8000_0020, 32'h8000_0024, 1, 64'd3);
    set_inputs(2'b10, 32'h0, 32'h0, 32'h8000_0004, 32'h0, 1'b0, 5'd7, 32'h8000_0000, 32'h8000_0040);
    run_instr("nowr", 1'b0, 5'd7, 32'h8000_0004, 32'h8000_0000, 32'h8000_0040, 0, 64'd4);
    check("nowr.wen_pulses", 64'(wen_cnt), 64'd0);

    // Back-to-back with lsu_valid held high
    wen_cnt = 0;
    lsu_valid = 1'b1;
    ifu_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      set_inputs(2'b11, 32'h0, 32'h0, 32'h0, 32'h1800 + i, 1'b1, 5'(i + 1),
                 32'h8000_1000 + 32'(i * 4), 32'h8000_1004 + 32'(i * 4));
      step();
      check("b2b.wen",   {63'd0, rf_wen}, 64'd1);
      check("b2b.wdata", {32'd0, rf_wdata}, 64'(32'h1800 + i));
      check("b2b.waddr", {59'd0, rf_waddr}, 64'(i + 1));
      step();
      check("b2b.valid", {63'd0, wbu_valid}, 64'd1);
      step();
      check("b2b.ready", {63'd0, wbu_ready}, 64'd1);
    end
    lsu_valid = 1'b0;
    ifu_ready = 1'b0;
    check("b2b.instret", instret, 64'd8);
    check("b2b.wen_pulses", 64'(wen_cnt), 64'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "timeout");
  end

endmodule
